// File: rtl/boxcar_decimator.sv
// boxcar_decimator: averages each non-overlapping block of 2^LOG2_DECIM
// accepted samples and offers one result per block on a valid/ready output.
// A result that completes while the output slot is still occupied is dropped
// and reported on o_overrun; results are never queued.
module boxcar_decimator #(
    parameter int DATA_WIDTH = 8,
    parameter int LOG2_DECIM = 2   // 0..8; 0 is a registered pass-through
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_overrun
);

    // Accumulator holds up to R full-scale samples, so it can never wrap.
    localparam int ACC_W = DATA_WIDTH + LOG2_DECIM;

    logic [ACC_W-1:0]      acc;
    logic [ACC_W-1:0]      sum;
    logic [DATA_WIDTH-1:0] result;
    logic                  last;
    logic                  block_done;
    logic                  slot_free;

    assign sum        = acc + ACC_W'(i_data);
    // Floor division by R: plain right shift, no rounding.
    assign result     = DATA_WIDTH'(sum >> LOG2_DECIM);
    assign block_done = i_valid && last;
    // Slot can take a new result if empty or being drained this cycle.
    assign slot_free  = !o_valid || i_ready;

    generate
        if (LOG2_DECIM > 0) begin : g_cnt
            logic [LOG2_DECIM-1:0] cnt;

            assign last = (cnt == {LOG2_DECIM{1'b1}});

            // Sample counter; wraps from R-1 back to 0 at the end of a block.
            always_ff @(posedge i_clk or posedge i_reset) begin
                if (i_reset)
                    cnt <= '0;
                else if (i_valid)
                    cnt <= cnt + 1'b1;
            end
        end else begin : g_nocnt
            // R = 1: every accepted sample completes a block.
            assign last = 1'b1;
        end
    endgenerate

    // Running sum of the current block; cleared when the block completes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            acc <= '0;
        else if (i_valid)
            acc <= last ? '0 : sum;
    end

    // Output slot: load on completion if free, else drop and flag overrun.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_valid   <= 1'b0;
            o_data    <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= block_done && !slot_free;
            if (block_done && slot_free) begin
                o_data  <= result;
                o_valid <= 1'b1;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_boxcar_decimator.sv
// Scoreboard bench for boxcar_decimator: stimulus pushes expected results
// (value and cycle of first presentation) and expected overrun cycles; a
// monitor per DUT pops and compares whenever a new result or pulse appears.
module tb_boxcar_decimator;

    typedef struct {
        int data;
        int cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       i_valid, i_ready;
    logic [7:0] i_data;
    logic       o_valid, o_overrun;
    logic [7:0] o_data;
    logic       i_valid0, i_ready0;
    logic [7:0] i_data0;
    logic       o_valid0, o_overrun0;
    logic [7:0] o_data0;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];
    exp_t sbq0[$];
    int   ovq[$];
    logic pv, phs, pv0, phs0;

    boxcar_decimator #(.DATA_WIDTH(8), .LOG2_DECIM(2)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_overrun(o_overrun)
    );

    boxcar_decimator #(.DATA_WIDTH(8), .LOG2_DECIM(0)) dut0 (
        .i_clk(clk), .i_reset(rst), .i_valid(i_valid0), .i_data(i_data0),
        .o_valid(o_valid0), .i_ready(i_ready0), .o_data(o_data0), .o_overrun(o_overrun0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic unexpected(input string nm, input int act);
        tests++;
        fails++;
        $display("FAIL %s: got %0d, required no event (cycle %0d)", nm, act, cyc);
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge.
    task automatic step(input logic v, input logic [7:0] d, input logic r);
        i_valid = v;
        i_data  = d;
        i_ready = r;
        @(posedge clk);
        #1;
    endtask

    // Expect a result first presented right after the coming edge.
    task automatic exp_res(input int d);
        sbq.push_back('{data: d, cyc: cyc + 1});
    endtask

    // Monitor for the R=4 instance: a new result is o_valid high after an
    // empty slot or after a completed handshake.
    always @(negedge clk) begin
        if (rst) begin
            pv  = 1'b0;
            phs = 1'b0;
        end else begin
            if (o_valid && (!pv || phs)) begin
                if (sbq.size() == 0) begin
                    unexpected("unexpected_result", int'(o_data));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result_data", int'(o_data), e.data);
                    chk("result_cycle", cyc, e.cyc);
                end
            end
            if (o_overrun) begin
                if (ovq.size() == 0)
                    unexpected("unexpected_overrun", cyc);
                else
                    chk("overrun_cycle", cyc, ovq.pop_front());
            end
            pv  = o_valid;
            phs = o_valid && i_ready;
        end
    end

    // Monitor for the pass-through (R=1) instance.
    always @(negedge clk) begin
        if (rst) begin
            pv0  = 1'b0;
            phs0 = 1'b0;
        end else begin
            if (o_valid0 && (!pv0 || phs0)) begin
                if (sbq0.size() == 0) begin
                    unexpected("unexpected_result_r1", int'(o_data0));
                end else begin
                    exp_t e;
                    e = sbq0.pop_front();
                    chk("result_data_r1", int'(o_data0), e.data);
                    chk("result_cycle_r1", cyc, e.cyc);
                end
            end
            if (o_overrun0)
                unexpected("unexpected_overrun_r1", cyc);
            pv0  = o_valid0;
            phs0 = o_valid0 && i_ready0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int samp [4];
        rst = 1'b1;
        i_valid = 0; i_data = 0; i_ready = 0;
        i_valid0 = 0; i_data0 = 0; i_ready0 = 0;
        @(posedge clk);
        #1;
        chk("reset_valid", int'(o_valid), 0);
        chk("reset_data", int'(o_data), 0);
        chk("reset_overrun", int'(o_overrun), 0);
        chk("reset_valid_r1", int'(o_valid0), 0);
        rst = 1'b0;
        step(0, 0, 1);

        // Basic block average: 10,20,30,40 -> 25, valid for one cycle.
        samp = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_res(25);
            step(1, samp[i][7:0], 1);
        end
        chk("basic_valid", int'(o_valid), 1);
        chk("basic_data", int'(o_data), 25);
        step(0, 0, 1);
        chk("basic_valid_drop", int'(o_valid), 0);
        chk("basic_data_hold", int'(o_data), 25);

        // Full scale then truncation: 255 then floor(5/4)=1.
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_res(255);
            step(1, 8'd255, 1);
        end
        samp = '{1, 1, 1, 2};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_res(1);
            step(1, samp[i][7:0], 1);
        end
        step(0, 0, 1);
        chk("trunc_data", int'(o_data), 1);

        // Gapped input: idle cycles must not advance the count.
        samp = '{4, 8, 12, 16};
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_res(10);
            step(1, samp[i][7:0], 1);
            if (i != 3) step(0, 0, 1);
        end
        step(0, 0, 1);
        step(0, 0, 1);

        // Backpressure: first 100 held, later blocks dropped with overrun.
        for (int i = 1; i <= 16; i++) begin
            if (i == 4) exp_res(100);
            if (i == 8 || i == 12 || i == 16) ovq.push_back(cyc + 1);
            step(1, (i <= 8) ? 8'd100 : 8'd50, 0);
            if (i >= 4) begin
                chk("bp_valid", int'(o_valid), 1);
                chk("bp_data", int'(o_data), 100);
            end
        end
        step(0, 0, 0);
        chk("bp_overrun_clear", int'(o_overrun), 0);
        step(0, 0, 1);
        chk("bp_drain_valid", int'(o_valid), 0);
        chk("bp_drain_data", int'(o_data), 100);
        step(0, 0, 1);

        // Load and consume in the same cycle: no bubble, no overrun.
        for (int i = 1; i <= 8; i++) begin
            if (i == 4) exp_res(20);
            if (i == 8) exp_res(60);
            step(1, (i <= 4) ? 8'd20 : 8'd60, i == 8);
        end
        chk("swap_valid", int'(o_valid), 1);
        chk("swap_data", int'(o_data), 60);
        chk("swap_overrun", int'(o_overrun), 0);
        step(0, 0, 1);
        chk("swap_drain_valid", int'(o_valid), 0);

        // Reset with a pending output and a partial block.
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) exp_res(60);
            step(1, 8'd60, 0);
        end
        step(1, 8'd200, 0);
        step(1, 8'd200, 0);
        i_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", int'(o_valid), 0);
        chk("async_rst_data", int'(o_data), 0);
        chk("async_rst_overrun", int'(o_overrun), 0);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 4; i++) begin
            if (i == 4) exp_res(8);
            step(1, 8'd8, 1);
        end
        chk("post_rst_data", int'(o_data), 8);
        step(0, 0, 1);
        step(0, 0, 1);

        // R=1 instance: each sample appears one cycle later.
        samp = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            i_valid0 = 1'b1;
            i_data0  = samp[i][7:0];
            i_ready0 = 1'b1;
            sbq0.push_back('{data: samp[i], cyc: cyc + 1});
            step(0, 0, 1);
            chk("r1_data", int'(o_data0), samp[i]);
        end
        i_valid0 = 1'b0;
        step(0, 0, 1);
        chk("r1_drain_valid", int'(o_valid0), 0);

        repeat (3) step(0, 0, 1);
        chk("sb_left", sbq.size(), 0);
        chk("sb_left_r1", sbq0.size(), 0);
        chk("overrun_left", ovq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/boxcar_decimator.md
Name: boxcar_decimator

Overview:
- Downstream neighbour of the boxcar filter stage; consumes its 8-bit output stream.
- Averages each non-overlapping block of R = 2^LOG2_DECIM accepted samples and emits one result per block.
- The result is held in an output register with a valid/ready handshake toward the next stage.
- Lost results (downstream stall) are flagged, never silently queued.

Parameters:
- DATA_WIDTH, 8, sample width in and out (unsigned).
- LOG2_DECIM, 2, log2 of decimation factor R. Range 0..8; 0 gives a registered pass-through with handshake.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_valid  input  1  i_data is a new sample this cycle. No backpressure upstream; every i_valid cycle is accepted.
- i_data  input  DATA_WIDTH  unsigned sample from the boxcar filter stage.
- o_valid  output  1  o_data holds an unconsumed result.
- i_ready  input  1  downstream accepts o_data this cycle.
- o_data  output  DATA_WIDTH  block average.
- o_overrun  output  1  one-cycle pulse: a completed result was dropped.

Behaviour:
- Reset (async assert, sync release): acc=0, cnt=0, o_valid=0, o_data=0, o_overrun=0.
- Internal state:
  - acc: DATA_WIDTH+LOG2_DECIM bits, sized so it cannot overflow.
  - cnt: LOG2_DECIM bits (none when LOG2_DECIM=0).
- Accepted sample, i_valid=1 and cnt != R-1: acc <= acc + i_data; cnt <= cnt+1.
- Accepted sample, i_valid=1 and cnt == R-1 (block complete):
  - result = (acc + i_data) >> LOG2_DECIM, truncation (floor), no rounding.
  - acc <= 0; cnt <= 0.
- Output slot is free when o_valid=0, or when o_valid=1 and i_ready=1 in the same cycle.
- Block complete and slot free: o_data <= result; o_valid <= 1 on the next edge.
  - Latency: o_valid is high the cycle after the R-th sample's i_valid cycle.
- Block complete and slot not free (o_valid=1, i_ready=0):
  - Result is discarded; o_data and o_valid are unchanged.
  - o_overrun=1 for exactly the next cycle.
- o_valid=1, i_ready=1, no new result: o_valid <= 0; o_data holds its last value.
- o_valid=0 with i_ready=1: no effect.
- Load and consume in the same cycle: o_valid stays 1 and o_data takes the new result. No bubble, and this is not an overrun.
- o_data and o_valid change only as stated above. Once asserted, o_valid stays high until the handshake completes.
- i_valid gaps: acc and cnt hold. Blocks are defined by accepted samples, not cycles.
- Reset mid-block or with o_valid=1: the partial block and the pending output are discarded. After release, counting restarts from sample 0.
- Throughput: one sample per cycle sustained. One result per R samples.

Test Plan (DATA_WIDTH=8, LOG2_DECIM=2 unless noted):
- i_ready=1, i_valid=1 for 4 cycles with 10,20,30,40 -> o_data=25, o_valid=1 for exactly one cycle, starting the cycle after 40; o_overrun stays 0.
- Full scale 255,255,255,255, then truncation case 1,1,1,2 -> results 255 then 1; no wrap.
- i_valid toggling 1/0 across samples 4,8,12,16 -> single result 10, one cycle after the 4th accepted sample; idle cycles do not advance cnt.
- Backpressure: i_ready=0, stream 8 samples of 100 then 8 samples of 50 ->
  - o_data=100 and o_valid stays high throughout.
  - o_overrun pulses one cycle after sample 8 and again after sample 12 (and 16).
  - Then raise i_ready -> 100 consumed, o_valid falls.
- Same-cycle load/consume: continuous i_valid, i_ready high only in the cycle the second result completes -> o_valid stays 1 and o_data switches to the second result with no overrun.
- Reset mid-operation:
  - After 2 samples of 200, pulse i_reset asynchronously between edges -> outputs 0 immediately.
  - Then 4 samples of 8 -> o_data=8.
- Repeat the first scenario with LOG2_DECIM=0: each sample appears on o_data one cycle later.
